ncl_threshold_gate: RTL and testbench
=====================================

Name: ncl_threshold_gate

Overview:
- Clocked emulation of a generic NCL M-of-N threshold gate with hysteresis, plus an optional inverted output and a programmable reset value.
- One parameterisation covers the team's three gate uses:
  - TH14: 1-of-4 completion OR.
  - TH22: 2-of-2 C-element, used for data-rail latching.
  - THnotN: inverting TH11 with init, used for completion-to-enable and auto-producer feedback.
- Instantiated inside NCL pipeline stages: four-rail data latches, completion detection and enable generation.

Parameters:
- N, 4, number of inputs (1..8).
- M, 1, threshold (1..N); output asserts when at least M inputs are 1.
- INVERT, 0, 1 = output is the complement of the hysteresis state (THnotN form).
- RST_VAL, 0, value driven on z while init is high and immediately after its release.

Ports:
- clk  input  1  state-update clock, rising edge.
- init  input  1  asynchronous active-high reset; the codebase's NCL init signal.
- a  input  N  gate inputs (one rail per bit).
- z  output  1  gate output.

Behaviour:
- Internal state bit s; output z = s XOR INVERT.
- Reset:
  - While init = 1, s = RST_VAL XOR INVERT asynchronously, so z = RST_VAL.
  - Release takes effect on the next rising clk edge after init falls.
- cnt = population count of a (width clog2(N+1)), combinational.
- Update on each rising clk edge when init = 0:
  - If cnt >= M, s <= 1 (set).
  - Else if cnt == 0, s <= 0 (clear, NULL wavefront complete).
  - Else s holds (hysteresis).
- Latency: exactly one clock from an input change to the z change.
- Combinational special cases follow from the rule, with no extra logic:
  - M = 1 gives a plain registered OR (no hold region).
  - M = N = 1 gives a registered buffer, or an inverter when INVERT = 1.
- Configured uses:
  - TH14: N=4, M=1, INVERT=0, RST_VAL=0.
  - TH22: N=2, M=2, INVERT=0, RST_VAL=0.
  - THnotN: N=1, M=1, INVERT=1, RST_VAL=0. z = 0 during init; z = ~a[0] one clock after release.
- Boundary conditions:
  - Partial input sets (0 < cnt < M) never change z.
  - Simultaneous set and clear are impossible, because M >= 1.
  - init asserted mid-operation overrides any state immediately.
  - Inputs with X/Z are not guaranteed.
- Elaboration errors: M < 1, M > N, N < 1, N > 8, RST_VAL not in {0,1}.

Decomposition:
- Shared package ncl_pkg:
  - Localparams for the three standard configurations (TH14_*, TH22_*, THNOTN_*).
  - A clog2 helper function.
- One sub-module, ncl_popcount (parameter N, input N bits, output count), instantiated once.
- Thin wrappers for the TH14/TH22/THnotN configurations are optional and hold no logic.

Test Plan:
1. THnotN config: hold init=1 for 2 clocks with a=0 -> z=0. Release init -> z=1 on the first edge. Set a=1 -> z=0 one clock later. Set a=0 -> z=1 one clock later.
2. TH22 config, from reset with z=0:
   - a=01 -> z stays 0.
   - a=11 -> z=1 next edge.
   - a=10 -> z stays 1.
   - a=00 -> z=0 next edge.
   - a=01 -> z stays 0.
3. TH14 config: step a through 0001, 0010, 0100, 1000, each with a=0000 between -> z=1 one clock after each one-hot value, and 0 one clock after each 0000. a=1111 -> z=1.
4. Threshold sweep, N=4, M=3:
   - a=0011 -> z=0.
   - a=0111 -> z=1.
   - a=0001 -> z holds 1.
   - a=0000 -> z=0.
   - a=1011 -> z=1.
5. Mid-operation reset, TH22 with z=1 and a=11: pulse init high for less than one clock period between edges -> z=0 immediately. After release with a=11 -> z=1 on the next edge.
6. Integration, four-stage four-rail pipeline built from these cells:
   - Stage: THnotN enable plus 4×TH22 latches plus TH14 completion.
   - Producer rail 0 is a THnotN of first-stage completion; rails 1..3 are tied 0.
   - Consumer is a TH14 on the last stage's rails.
   - Init for 2 clocks, then run 100 clocks -> rail-0 DATA/NULL wavefronts propagate stage by stage.
   - Each stage's z[0] toggles periodically; z[3:1] stay 0; no stage's completion is ever high while its successor's enable is low and its data is still NULL (no wavefront overrun).

Source files
------------

// File: rtl/ncl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ncl_pkg
// Description : Shared constants for NCL threshold gates: the standard gate
//               configurations and a width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ncl_pkg;

    // TH14: 1-of-4 completion OR
    localparam int TH14_N       = 4;
    localparam int TH14_M       = 1;
    localparam int TH14_INVERT  = 0;
    localparam int TH14_RST_VAL = 0;

    // TH22: 2-of-2 C-element for data-rail latching
    localparam int TH22_N       = 2;
    localparam int TH22_M       = 2;
    localparam int TH22_INVERT  = 0;
    localparam int TH22_RST_VAL = 0;

    // THnotN: inverting TH11 used for enable and auto-producer feedback
    localparam int THNOTN_N       = 1;
    localparam int THNOTN_M       = 1;
    localparam int THNOTN_INVERT  = 1;
    localparam int THNOTN_RST_VAL = 0;

    function automatic int ncl_clog2(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : ncl_pkg
`default_nettype wire

// File: rtl/ncl_popcount.sv
`default_nettype none
// ============================================================================
// Module      : ncl_popcount
// Description : Combinational population count of an N-bit rail vector.
// Revision    : 1.0 - initial release
// ============================================================================
module ncl_popcount
    import ncl_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = ncl_clog2(N + 1)
) (
    input  logic [N-1:0]  a,
    output logic [CW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CW'(a[i]);
        end
    end

endmodule : ncl_popcount
`default_nettype wire

// File: rtl/ncl_threshold_gate.sv
`default_nettype none
// ============================================================================
// Module      : ncl_threshold_gate
// Description : Clocked M-of-N NCL threshold gate with hysteresis, optional
//               inverted output and programmable init value.
// Revision    : 1.0 - initial release
// ============================================================================
module ncl_threshold_gate
    import ncl_pkg::*;
#(
    parameter int N       = 4,
    parameter int M       = 1,
    parameter int INVERT  = 0,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         init,
    input  logic [N-1:0] a,
    output logic         z
);

    localparam int              c_CW    = ncl_clog2(N + 1);
    localparam logic [c_CW-1:0] c_M     = c_CW'(M);
    localparam logic            c_INV   = (INVERT != 0);
    // State is stored pre-inversion so that z shows RST_VAL during init
    localparam logic            c_S_RST = (RST_VAL != 0) ^ c_INV;

    generate
        if (N < 1 || N > 8) begin : g_bad_n
            $error("ncl_threshold_gate: N must be in 1..8");
        end
        if (M < 1 || M > N) begin : g_bad_m
            $error("ncl_threshold_gate: M must be in 1..N");
        end
        if (RST_VAL != 0 && RST_VAL != 1) begin : g_bad_rst_val
            $error("ncl_threshold_gate: RST_VAL must be 0 or 1");
        end
        if (INVERT != 0 && INVERT != 1) begin : g_bad_invert
            $error("ncl_threshold_gate: INVERT must be 0 or 1");
        end
    endgenerate

    logic [c_CW-1:0] w_cnt;
    logic            r_s;

    ncl_popcount #(
        .N  (N),
        .CW (c_CW)
    ) u_popcount (
        .a     (a),
        .count (w_cnt)
    );

    // Set on a complete DATA set, clear on full NULL, otherwise hold
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_s <= c_S_RST;
        end else if (w_cnt >= c_M) begin
            r_s <= 1'b1;
        end else if (w_cnt == '0) begin
            r_s <= 1'b0;
        end
    end

    assign z = r_s ^ c_INV;

endmodule : ncl_threshold_gate
`default_nettype wire

// File: tb/tb_ncl_threshold_gate.sv
`default_nettype none
// ============================================================================
// Module      : tb_ncl_threshold_gate
// Description : Directed self-checking bench for ncl_threshold_gate, including
//               a four-stage four-rail NCL pipeline built from the gate.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ncl_threshold_gate;
    import ncl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       init;
    logic [0:0] a_nn;
    logic       z_nn;
    logic [1:0] a_22;
    logic       z_22;
    logic [3:0] a_14;
    logic       z_14;
    logic [3:0] a_43;
    logic       z_43;
    logic [1:0] a_r1;
    logic       z_r1;

    int errors = 0;
    int checks = 0;

    ncl_threshold_gate #(.N(THNOTN_N), .M(THNOTN_M), .INVERT(THNOTN_INVERT), .RST_VAL(THNOTN_RST_VAL))
        u_thnotn (.clk(clk), .init(init), .a(a_nn), .z(z_nn));
    ncl_threshold_gate #(.N(TH22_N), .M(TH22_M), .INVERT(TH22_INVERT), .RST_VAL(TH22_RST_VAL))
        u_th22 (.clk(clk), .init(init), .a(a_22), .z(z_22));
    ncl_threshold_gate #(.N(TH14_N), .M(TH14_M), .INVERT(TH14_INVERT), .RST_VAL(TH14_RST_VAL))
        u_th14 (.clk(clk), .init(init), .a(a_14), .z(z_14));
    ncl_threshold_gate #(.N(4), .M(3), .INVERT(0), .RST_VAL(0))
        u_th34 (.clk(clk), .init(init), .a(a_43), .z(z_43));
    ncl_threshold_gate #(.N(2), .M(2), .INVERT(0), .RST_VAL(1))
        u_th22_set (.clk(clk), .init(init), .a(a_r1), .z(z_r1));

    // Four-stage four-rail pipeline: rail[0] is the producer, rail[k+1] stage k
    logic [4:0][3:0] rail;
    logic [4:0]      comp;
    logic [3:0]      en;
    logic            prod;

    ncl_threshold_gate #(.N(THNOTN_N), .M(THNOTN_M), .INVERT(THNOTN_INVERT), .RST_VAL(THNOTN_RST_VAL))
        u_prod (.clk(clk), .init(init), .a(comp[0]), .z(prod));
    assign rail[0] = {3'b000, prod};

    genvar k, r;
    generate
        for (k = 0; k < 4; k++) begin : g_stage
            ncl_threshold_gate #(.N(THNOTN_N), .M(THNOTN_M), .INVERT(THNOTN_INVERT), .RST_VAL(THNOTN_RST_VAL))
                u_en (.clk(clk), .init(init), .a(comp[k+1]), .z(en[k]));
            for (r = 0; r < 4; r++) begin : g_rail
                ncl_threshold_gate #(.N(TH22_N), .M(TH22_M), .INVERT(TH22_INVERT), .RST_VAL(TH22_RST_VAL))
                    u_latch (.clk(clk), .init(init), .a({en[k], rail[k][r]}), .z(rail[k+1][r]));
            end
            ncl_threshold_gate #(.N(TH14_N), .M(TH14_M), .INVERT(TH14_INVERT), .RST_VAL(TH14_RST_VAL))
                u_comp (.clk(clk), .init(init), .a(rail[k+1]), .z(comp[k]));
        end
    endgenerate

    ncl_threshold_gate #(.N(TH14_N), .M(TH14_M), .INVERT(TH14_INVERT), .RST_VAL(TH14_RST_VAL))
        u_consumer (.clk(clk), .init(init), .a(rail[4]), .z(comp[4]));

    typedef struct {
        int       sel;
        logic [3:0] a;
        logic       z;
    } vec_t;

    vec_t vecs[$];
    logic prev_z [3];

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic zsel(input int sel);
        case (sel)
            0:       return z_22;
            1:       return z_14;
            default: return z_43;
        endcase
    endfunction

    task automatic set_a(input int sel, input logic [3:0] v);
        case (sel)
            0:       a_22 = v[1:0];
            1:       a_14 = v;
            default: a_43 = v;
        endcase
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   toggles [5];
        logic [4:0] prev0;
        int   upper_bad;
        int   overrun;

        init = 1'b1;
        a_nn = 1'b0;
        a_22 = 2'b00;
        a_14 = 4'b0000;
        a_43 = 4'b0000;
        a_r1 = 2'b00;

        // THnotN and reset values
        tick();
        tick();
        check("init_thnotn", z_nn, 1'b0);
        check("init_th22", z_22, 1'b0);
        check("init_th14", z_14, 1'b0);
        check("init_th34", z_43, 1'b0);
        check("init_rstval1", z_r1, 1'b1);
        init = 1'b0;
        #1;
        check("release_before_edge", z_nn, 1'b0);
        tick();
        check("release_thnotn", z_nn, 1'b1);
        check("release_rstval1", z_r1, 1'b0);
        a_nn = 1'b1;
        #1;
        check("thnotn_a1_pre", z_nn, 1'b1);
        tick();
        check("thnotn_a1", z_nn, 1'b0);
        a_nn = 1'b0;
        tick();
        check("thnotn_a0", z_nn, 1'b1);

        // sel: 0 = TH22, 1 = TH14, 2 = 3-of-4
        vecs.push_back('{sel: 0, a: 4'b0001, z: 1'b0});
        vecs.push_back('{sel: 0, a: 4'b0011, z: 1'b1});
        vecs.push_back('{sel: 0, a: 4'b0010, z: 1'b1});
        vecs.push_back('{sel: 0, a: 4'b0000, z: 1'b0});
        vecs.push_back('{sel: 0, a: 4'b0001, z: 1'b0});
        vecs.push_back('{sel: 1, a: 4'b0001, z: 1'b1});
        vecs.push_back('{sel: 1, a: 4'b0000, z: 1'b0});
        vecs.push_back('{sel: 1, a: 4'b0010, z: 1'b1});
        vecs.push_back('{sel: 1, a: 4'b0000, z: 1'b0});
        vecs.push_back('{sel: 1, a: 4'b0100, z: 1'b1});
        vecs.push_back('{sel: 1, a: 4'b0000, z: 1'b0});
        vecs.push_back('{sel: 1, a: 4'b1000, z: 1'b1});
        vecs.push_back('{sel: 1, a: 4'b0000, z: 1'b0});
        vecs.push_back('{sel: 1, a: 4'b1111, z: 1'b1});
        vecs.push_back('{sel: 2, a: 4'b0011, z: 1'b0});
        vecs.push_back('{sel: 2, a: 4'b0111, z: 1'b1});
        vecs.push_back('{sel: 2, a: 4'b0001, z: 1'b1});
        vecs.push_back('{sel: 2, a: 4'b0000, z: 1'b0});
        vecs.push_back('{sel: 2, a: 4'b1011, z: 1'b1});

        for (int s = 0; s < 3; s++) prev_z[s] = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            set_a(vecs[i].sel, vecs[i].a);
            #1;
            check($sformatf("vec%0d_pre_edge", i), zsel(vecs[i].sel), prev_z[vecs[i].sel]);
            tick();
            check($sformatf("vec%0d_sel%0d_a%b", i, vecs[i].sel, vecs[i].a), zsel(vecs[i].sel), vecs[i].z);
            prev_z[vecs[i].sel] = vecs[i].z;
        end

        // Mid-operation asynchronous init pulse
        a_22 = 2'b11;
        a_r1 = 2'b00;
        tick();
        check("midrst_setup", z_22, 1'b1);
        #2;
        init = 1'b1;
        #1;
        check("midrst_th22_immediate", z_22, 1'b0);
        check("midrst_rstval1_immediate", z_r1, 1'b1);
        init = 1'b0;
        #1;
        check("midrst_hold_until_edge", z_22, 1'b0);
        tick();
        check("midrst_recover", z_22, 1'b1);

        // Pipeline integration
        init = 1'b1;
        tick();
        tick();
        init = 1'b0;
        for (int s = 0; s < 5; s++) toggles[s] = 0;
        prev0     = '0;
        upper_bad = 0;
        overrun   = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            for (int s = 0; s < 4; s++) begin
                if (rail[s+1][0] !== prev0[s]) toggles[s]++;
                prev0[s] = rail[s+1][0];
                if (rail[s+1][3:1] !== 3'b000) upper_bad++;
            end
            if (comp[4] !== prev0[4]) toggles[4]++;
            prev0[4] = comp[4];
            for (int s = 0; s < 3; s++) begin
                if (comp[s] && !en[s+1] && !rail[s+2][0]) overrun++;
            end
        end
        for (int s = 0; s < 4; s++) begin
            check_int($sformatf("pipe_stage%0d_toggles", s), toggles[s], 16, 28);
        end
        check_int("pipe_consumer_toggles", toggles[4], 16, 28);
        check_int("pipe_upper_rails_nonzero", upper_bad, 0, 0);
        check_int("pipe_overrun", overrun, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ncl_threshold_gate
`default_nettype wire
